// File: rtl/mod_sha256_compress.sv
// SHA-256 single-block compression engine.
// Consumes W[0..63] one word per accept, folds result into HASH.
module mod_sha256_compress (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         CHAIN,
  input  logic [31:0]  W_IN,
  input  logic         W_VALID,
  output logic         W_READY,
  output logic [255:0] HASH,
  output logic         BUSY,
  output logic         DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      state;
  logic [5:0]  t;
  logic [255:0] hreg;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic        ready_q, busy_q, done_q;

  logic [31:0] s0, s1, ch, maj, t1, t2;

  function automatic logic [31:0] ror(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  // one round of the compression function on the current word
  always_comb begin
    s1  = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
    ch  = (e & f) ^ (~e & g);
    t1  = h + s1 + ch + KROM[t] + W_IN;
    s0  = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t2  = s0 + maj;
  end

  // block sequencer, working variables and chaining value
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      t       <= '0;
      hreg    <= IV;
      {a, b, c, d, e, f, g, h} <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            if (!CHAIN) begin
              hreg <= IV;
              {a, b, c, d, e, f, g, h} <= IV;
            end else begin
              {a, b, c, d, e, f, g, h} <= hreg;
            end
            t       <= '0;
            state   <= S_ROUND;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ROUND: begin
          if (W_VALID) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
            if (t == 6'd63) begin
              t       <= '0;
              state   <= S_FINAL;
              ready_q <= 1'b0;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        S_FINAL: begin
          hreg <= {
            hreg[255:224] + a, hreg[223:192] + b,
            hreg[191:160] + c, hreg[159:128] + d,
            hreg[127:96]  + e, hreg[95:64]   + f,
            hreg[63:32]   + g, hreg[31:0]    + h
          };
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign W_READY = ready_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign HASH    = hreg;

endmodule

// File: tb/tb_mod_sha256_compress.sv
// Self-checking bench for mod_sha256_compress.
// Directed digests plus random blocks against a behavioural model.
module tb_mod_sha256_compress;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sch_t [64];

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         CHAIN;
  logic [31:0]  W_IN;
  logic         W_VALID;
  logic         W_READY;
  logic [255:0] HASH;
  logic         BUSY;
  logic         DONE;

  int ncmp = 0;
  int nerr = 0;

  mod_sha256_compress dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .CHAIN   (CHAIN),
    .W_IN    (W_IN),
    .W_VALID (W_VALID),
    .W_READY (W_READY),
    .HASH    (HASH),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(
    input string        tag,
    input logic [255:0] obs,
    input logic [255:0] expct
  );
    ncmp++;
    assert (obs === expct) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expct);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // message schedule expansion from a 16-word block
  task automatic expand(input blk_t m, output sch_t w);
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin
        w[i] = m[i];
      end else begin
        w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10))
             + w[i-7]
             + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3))
             + w[i-16];
      end
    end
  endtask

  // reference compression: rotate an 8-word array, then add back
  task automatic ref_block(
    input  logic [255:0] hin,
    input  sch_t         w,
    output logic [255:0] hout
  );
    logic [31:0] v [8];
    logic [31:0] x1, x2;
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int r = 0; r < 64; r++) begin
      x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) | (~v[4] & v[6])) + KT[r] + w[r];
      x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) | (v[2] & (v[0] | v[1])));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++)
      hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
  endtask

  // drive one block; cyc counts cycles with START's cycle as 0
  task automatic run_block(
    input  sch_t w,
    input  bit   chain,
    input  bit   stall,
    input  int   abort_at,
    input  bit   pulse,
    output int   done_cyc,
    output int   nstall
  );
    int cyc;
    int idx;
    bit drop;
    bit acc;
    logic [255:0] h0;
    @(negedge CLK);
    START = 1'b1;
    CHAIN = chain;
    @(negedge CLK);
    START = 1'b0;
    cyc = 1;
    idx = 0;
    nstall = 0;
    h0 = HASH;
    chk("ready_round", {255'd0, W_READY}, 256'd1);
    while (idx < 64 && cyc < 400) begin
      if (abort_at >= 0 && idx == abort_at) begin
        RST = 1'b1;
        START = 1'b1;
        W_VALID = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        START = 1'b0;
        W_VALID = 1'b0;
        chk("rst_busy", {255'd0, BUSY}, 256'd0);
        chk("rst_ready", {255'd0, W_READY}, 256'd0);
        chk("rst_hash", HASH, IV);
        repeat (3) @(negedge CLK);
        chk("rst_hold", HASH, IV);
        done_cyc = -1;
        return;
      end
      drop = stall && nstall < 24
          && ($urandom_range(0, 1) == 1 || idx >= 40);
      W_VALID = !drop;
      W_IN = drop ? $urandom : w[idx];
      if (drop) nstall++;
      START = pulse && (cyc == 10);
      acc = W_READY && W_VALID;
      @(negedge CLK);
      cyc++;
      if (acc) idx++;
      if (cyc == 40) chk("hash_stable", HASH, h0);
    end
    W_VALID = 1'b0;
    START = 1'b0;
    while (DONE !== 1'b1 && cyc < 400) begin
      @(negedge CLK);
      cyc++;
    end
    chk("done_seen", {255'd0, DONE}, 256'd1);
    done_cyc = cyc;
    if (pulse) START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("idle_after", {255'd0, BUSY}, 256'd0);
    if (pulse) begin
      @(negedge CLK);
      chk("no_extra_busy", {255'd0, BUSY}, 256'd0);
    end
  endtask

  blk_t m;
  sch_t w_abc, w_emp, w_b1, w_b2, w;
  logic [255:0] href;
  int dc, ns;
  bit ch;

  initial begin
    RST = 1'b1;
    START = 1'b0;
    CHAIN = 1'b0;
    W_IN = '0;
    W_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready0", {255'd0, W_READY}, 256'd0);
    chk("rst_busy0", {255'd0, BUSY}, 256'd0);
    chk("rst_done0", {255'd0, DONE}, 256'd0);
    chk("rst_hash0", HASH, IV);
    RST = 1'b0;

    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0] = 32'h61626380;
    m[15] = 32'h00000018;
    expand(m, w_abc);
    m[0] = 32'h80000000;
    m[15] = 32'h0;
    expand(m, w_emp);
    m = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    expand(m, w_b1);
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[15] = 32'h000001c0;
    expand(m, w_b2);

    run_block(w_abc, 1'b0, 1'b0, -1, 1'b0, dc, ns);
    chk("abc_latency", 256'(dc), 256'd66);
    chk("abc_digest", HASH, D_ABC);
    ref_block(IV, w_abc, href);
    chk("abc_model", HASH, href);

    run_block(w_emp, 1'b0, 1'b0, -1, 1'b0, dc, ns);
    chk("empty_digest", HASH, D_EMPTY);

    run_block(w_abc, 1'b0, 1'b1, -1, 1'b0, dc, ns);
    chk("stall_count", 256'(ns), 256'd24);
    chk("stall_latency", 256'(dc), 256'(66 + ns));
    chk("stall_digest", HASH, D_ABC);

    run_block(w_b1, 1'b0, 1'b0, -1, 1'b0, dc, ns);
    run_block(w_b2, 1'b1, 1'b0, -1, 1'b0, dc, ns);
    chk("two_block", HASH, D_TWO);

    run_block(w_abc, 1'b0, 1'b0, 30, 1'b0, dc, ns);
    run_block(w_abc, 1'b0, 1'b0, -1, 1'b0, dc, ns);
    chk("post_rst_abc", HASH, D_ABC);

    run_block(w_emp, 1'b0, 1'b0, -1, 1'b1, dc, ns);
    chk("pulse_latency", 256'(dc), 256'd66);
    chk("pulse_digest", HASH, D_EMPTY);

    href = HASH;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) m[i] = $urandom;
      expand(m, w);
      ch = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!ch) href = IV;
      ref_block(href, w, href);
      run_block(w, ch, 1'($urandom_range(0, 1)), -1, 1'b0, dc, ns);
      chk("rand_latency", 256'(dc), 256'(66 + ns));
      chk("rand_digest", HASH, href);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mod_sha256_compress.md
MOD_SHA256_COMPRESS -- requirements
Module: mod_sha256_compress

Interface
REQ-001 No parameters; the module SHALL be fixed at SHA-256: 32-bit words, 64 rounds, 8-word state.
REQ-002 CLK  input  1  rising-edge clock; all state updates on posedge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  begin one 512-bit block; sampled only in IDLE.
REQ-005 CHAIN  input  1  sampled with START: 0 = load standard IV into H, 1 = continue from current H.
REQ-006 W_IN  input  32  message-schedule word W[t], t = 0..63 in order.
REQ-007 W_VALID  input  1  W_IN holds a valid word.
REQ-008 W_READY  output  1  module accepts a word this cycle.
REQ-009 HASH  output  256  {H0,H1,...,H7}, H0 in bits [255:224].
REQ-010 BUSY  output  1  high in any state other than IDLE.
REQ-011 DONE  output  1  one-cycle pulse when HASH is updated with a finished block.

Function
REQ-012 States SHALL be IDLE, ROUND, FINAL, DONE; the encoding is free.
REQ-013 IDLE with START=1: load a..h from H (after the optional IV load per CHAIN), clear round counter t to 0, go to ROUND; START outside IDLE is ignored.
REQ-014 IV SHALL be 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
REQ-015 W_READY SHALL be 1 only in ROUND; a word is accepted on a cycle with W_VALID & W_READY.
REQ-016 Each accept performs one FIPS 180-4 round: T1=h+S1(e)+Ch(e,f,g)+K[t]+W_IN, T2=S0(a)+Maj(a,b,c); then h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2; t increments.
REQ-017 All additions SHALL be modulo 2^32; carries discarded.
REQ-018 K[0..63] SHALL be an internal constant ROM indexed by t (K[0]=428a2f98, K[63]=c67178f2).
REQ-019 ROUND with W_VALID=0: a..h and t SHALL hold unchanged (stall of any length).
REQ-020 The accept at t=63 SHALL go to FINAL; t never wraps past 63 while in ROUND.
REQ-021 FINAL (1 cycle): Hi = Hi + working var i, mod 2^32, for all 8 words; go to DONE.
REQ-022 DONE (1 cycle): DONE=1, go to IDLE; START in this cycle is ignored.
REQ-023 Latency with W_VALID held high: START at cycle 0, accepts cycles 1..64, FINAL cycle 65, DONE=1 in cycle 66, HASH valid from cycle 66.
REQ-024 HASH SHALL change only in FINAL or on an IDLE START with CHAIN=0; it SHALL be stable during ROUND.

Reset
REQ-025 RST=1 at any posedge SHALL force IDLE, t=0, H=IV, a..h=0; RST overrides START and W_VALID.
REQ-026 Reset values: W_READY=0, BUSY=0, DONE=0, HASH=IV.
REQ-027 RST during ROUND or FINAL SHALL abandon the block; no partial result SHALL reach HASH.

Verification
REQ-028 Bench SHALL cover:
- "abc" block (W0=61626380, W1..W14=0, W15=00000018, W16..63 per schedule), CHAIN=0, W_VALID held high -> DONE in cycle 66, HASH=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- empty-message block (W0=80000000, all others 0 before expansion) -> HASH=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- "abc" with W_VALID randomly dropped (>=20 stall cycles) -> identical HASH, DONE delayed by exactly the stall count.
- two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", block 2 with CHAIN=1 -> HASH=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- RST asserted at t=30 -> next cycle BUSY=0, W_READY=0, HASH=IV; a following "abc" run gives the correct digest.
- START pulsed during ROUND and in the DONE cycle -> ignored; no extra BUSY period.
